// File: rtl/video_pattern_pkg.sv
// ---------------------------------------------------------------------------
// video_pattern_pkg
//
// Shared types and constants for the AXI4-Stream video test-pattern source.
//
// Contents:
//   pattern_e     - selectable test patterns (2-bit, matches pattern_sel)
//   state_e       - generator FSM states
//   R/B/G_LSB     - bit offsets of each 8-bit component inside the 24-bit beat
//   pack_rgb()    - builds a 24-bit beat from separate R, G, B components
//   BAR_*         - the eight colour-bar constants, left to right
//   cnt_w()       - counter width helper, never narrower than one bit
// ---------------------------------------------------------------------------
package video_pattern_pkg;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    RAMP    = 2'd1,
    CHECKER = 2'd2,
    GREY    = 2'd3
  } pattern_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // The sink expects the components in R, B, G order from MSB to LSB.
  localparam int unsigned R_LSB = 16;
  localparam int unsigned B_LSB = 8;
  localparam int unsigned G_LSB = 0;

  function automatic logic [23:0] pack_rgb(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    logic [23:0] p;
    p = '0;
    p[R_LSB +: 8] = r;
    p[G_LSB +: 8] = g;
    p[B_LSB +: 8] = b;
    return p;
  endfunction

  localparam logic [23:0] BAR_WHITE   = pack_rgb(8'hFF, 8'hFF, 8'hFF);
  localparam logic [23:0] BAR_YELLOW  = pack_rgb(8'hFF, 8'hFF, 8'h00);
  localparam logic [23:0] BAR_CYAN    = pack_rgb(8'h00, 8'hFF, 8'hFF);
  localparam logic [23:0] BAR_GREEN   = pack_rgb(8'h00, 8'hFF, 8'h00);
  localparam logic [23:0] BAR_MAGENTA = pack_rgb(8'hFF, 8'h00, 8'hFF);
  localparam logic [23:0] BAR_RED     = pack_rgb(8'hFF, 8'h00, 8'h00);
  localparam logic [23:0] BAR_BLUE    = pack_rgb(8'h00, 8'h00, 8'hFF);
  localparam logic [23:0] BAR_BLACK   = pack_rgb(8'h00, 8'h00, 8'h00);

  // $clog2(1) is 0; a position counter still needs one bit to exist.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// ---------------------------------------------------------------------------
// video_pattern_pixel
//
// Purely combinational colour generator: maps a pixel position, the pattern
// latched for the current frame and the frame's grey level to a 24-bit beat.
// The registered copy of this value lives in the top level.
//
// Parameters:
//   H_ACTIVE  - pixels per line (multiple of 8); sets the colour-bar width
//   XW, YW    - widths of the x and y position inputs
// Ports:
//   x     in  XW  horizontal position
//   y     in  YW  vertical position
//   pat   in  2   pattern for this frame
//   grey  in  8   grey level for the GREY pattern
//   rgb   out 24  pixel value, R/B/G packed per video_pattern_pkg offsets
// ---------------------------------------------------------------------------
module video_pattern_pixel
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 64,
  parameter int XW       = 6,
  parameter int YW       = 6
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  pattern_e      pat,
  input  logic [7:0]    grey,
  output logic [23:0]   rgb
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;
  logic [7:0] ramp;
  logic       x_b3;
  logic       y_b3;

  // NOTE: every signal assigned in a combinational block gets a value on
  // every path (defaults first); a missed path would infer a latch.
  always_comb begin
    bar  = 3'(32'(x) / BAR_W);
    ramp = 8'(x);
    // Shift before narrowing so narrow counters (fewer than 4 bits) read 0.
    x_b3 = 1'(x >> 3);
    y_b3 = 1'(y >> 3);
    rgb  = '0;

    unique case (pat)
      BARS: begin
        unique case (bar)
          3'd0: rgb = BAR_WHITE;
          3'd1: rgb = BAR_YELLOW;
          3'd2: rgb = BAR_CYAN;
          3'd3: rgb = BAR_GREEN;
          3'd4: rgb = BAR_MAGENTA;
          3'd5: rgb = BAR_RED;
          3'd6: rgb = BAR_BLUE;
          3'd7: rgb = BAR_BLACK;
        endcase
      end
      RAMP:    rgb = pack_rgb(ramp, ramp, ramp);
      CHECKER: rgb = (x_b3 ^ y_b3) ? BAR_WHITE : BAR_BLACK;
      GREY:    rgb = pack_rgb(grey, grey, grey);
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
//
// AXI4-Stream video source producing whole frames of a selectable test
// pattern, one pixel per clock while the sink is ready. SOF is flagged on
// tuser at pixel (0,0), EOL on tlast at the last pixel of every line.
// Frames are never truncated: enable and pattern_sel are only looked at when
// a frame starts (from IDLE, or at the end of the previous frame).
//
// Parameters:
//   H_ACTIVE  pixels per line (multiple of 8, >= 8)
//   V_ACTIVE  lines per frame (>= 1)
// Ports:
//   clk                     in   1   sole clock, rising edge
//   ap_rst_n                in   1   asynchronous active-low reset
//   enable                  in   1   start / continue frame generation
//   pattern_sel             in   2   0 bars, 1 ramp, 2 checker, 3 grey
//   video_in_stream_tdata   out  24  pixel [23:16] R, [15:8] B, [7:0] G
//   video_in_stream_tuser   out  1   start of frame
//   video_in_stream_tlast   out  1   end of line
//   video_in_stream_tvalid  out  1   beat valid
//   video_in_stream_tready  in   1   sink ready
//   frame_done              out  1   pulse after the last beat of a frame
//   frame_count             out  16  completed frames, wrapping
// ---------------------------------------------------------------------------
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 64,
  parameter int V_ACTIVE = 48
) (
  input  logic        clk,
  input  logic        ap_rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] video_in_stream_tdata,
  output logic        video_in_stream_tuser,
  output logic        video_in_stream_tlast,
  output logic        video_in_stream_tvalid,
  input  logic        video_in_stream_tready,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int XW = cnt_w(H_ACTIVE);
  localparam int YW = cnt_w(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  pattern_e      pat_q, pat_d;
  logic [7:0]    grey_q, grey_d;
  logic [15:0]   fc_d;
  logic [23:0]   pix;

  logic xfer;       // a beat is accepted at this edge
  logic last_pix;   // the beat on the bus is the last of the frame
  logic frame_end;  // last beat accepted at this edge
  logic start;      // a new frame begins at this edge
  logic advance;    // step to the next pixel inside the current frame

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (enable)                 state_d = ACTIVE;
      ACTIVE: if (frame_end && !enable)   state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath control
  // -------------------------------------------------------------------------
  // tvalid is 1 throughout ACTIVE, so a transfer is just ACTIVE & tready.
  always_comb begin
    xfer      = (state_q == ACTIVE) && video_in_stream_tready;
    last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
    frame_end = xfer && last_pix;
    start     = ((state_q == IDLE) && enable) || (frame_end && enable);
    advance   = xfer && !last_pix;

    fc_d   = frame_count + (frame_end ? 16'd1 : 16'd0);
    x_d    = x_q;
    y_d    = y_q;
    pat_d  = pat_q;
    grey_d = grey_q;

    if (start || frame_end) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // The grey level of a frame is the count of frames completed before it,
    // including the one finishing at this very edge.
    if (start) begin
      pat_d  = pattern_e'(pattern_sel);
      grey_d = fc_d[7:0];
    end
  end

  // Colour of the pixel that will be on the bus after this edge.
  video_pattern_pixel #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_pixel (
    .x    (x_d),
    .y    (y_d),
    .pat  (pat_d),
    .grey (grey_d),
    .rgb  (pix)
  );

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  // Beat fields only reload when a new pixel is presented, which keeps them
  // stable for as long as the sink stalls.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      x_q                    <= '0;
      y_q                    <= '0;
      pat_q                  <= BARS;
      grey_q                 <= '0;
      frame_count            <= '0;
      frame_done             <= 1'b0;
      video_in_stream_tvalid <= 1'b0;
      video_in_stream_tdata  <= '0;
      video_in_stream_tuser  <= 1'b0;
      video_in_stream_tlast  <= 1'b0;
    end else begin
      x_q                    <= x_d;
      y_q                    <= y_d;
      pat_q                  <= pat_d;
      grey_q                 <= grey_d;
      frame_count            <= fc_d;
      frame_done             <= frame_end;
      video_in_stream_tvalid <= (state_d == ACTIVE);
      if (start || advance) begin
        video_in_stream_tdata <= pix;
        // Only a frame start lands on (0,0); advancing never wraps to it.
        video_in_stream_tuser <= start;
        video_in_stream_tlast <= (x_d == X_LAST);
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_gen
//
// Directed bench for video_pattern_gen with default geometry (64 x 48).
// Drives inputs and samples outputs 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_video_pattern_gen;

  localparam int H    = 64;
  localparam int V    = 48;
  localparam int NPIX = H * V;

  logic        clk         = 1'b0;
  logic        ap_rst_n    = 1'b0;
  logic        enable      = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        tready      = 1'b0;
  logic [23:0] tdata;
  logic        tuser;
  logic        tlast;
  logic        tvalid;
  logic        frame_done;
  logic [15:0] frame_count;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [23:0] cap [NPIX];

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk                    (clk),
    .ap_rst_n               (ap_rst_n),
    .enable                 (enable),
    .pattern_sel            (pattern_sel),
    .video_in_stream_tdata  (tdata),
    .video_in_stream_tuser  (tuser),
    .video_in_stream_tlast  (tlast),
    .video_in_stream_tvalid (tvalid),
    .video_in_stream_tready (tready),
    .frame_done             (frame_done),
    .frame_count            (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hand-written reference colours: R,B,G byte order on the bus.
  function automatic logic [23:0] model(input int pat, input int x, input int y,
                                        input logic [7:0] g);
    logic [7:0] xv;
    xv = 8'(x);
    case (pat)
      0: begin
        case (x / 8)
          0:       return 24'hFFFFFF;  // white
          1:       return 24'hFF00FF;  // yellow
          2:       return 24'h00FFFF;  // cyan
          3:       return 24'h0000FF;  // green
          4:       return 24'hFFFF00;  // magenta
          5:       return 24'hFF0000;  // red
          6:       return 24'h00FF00;  // blue
          default: return 24'h000000;  // black
        endcase
      end
      1:       return {xv, xv, xv};
      2:       return (((x / 8) + (y / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      default: return {g, g, g};
    endcase
  endfunction

  // Consumes one frame starting at the current sample point. At accepted
  // beat ev_at, enable/pattern_sel are rewritten (ev_at < 0: never).
  task automatic run_frame(input string tag, input int pat, input logic [7:0] grey,
                           input bit bp, input int ev_at, input logic ev_en,
                           input logic [1:0] ev_sel);
    int          x = 0;
    int          y = 0;
    int          beats = 0;
    int          cycles = 0;
    bit          stalled = 1'b0;
    logic [25:0] held = '0;
    while (beats < NPIX && cycles < 20000) begin
      tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      check({tag, " tvalid"}, 32'(tvalid), 32'd1);
      if (beats > 0) check({tag, " frame_done low"}, 32'(frame_done), 32'd0);
      if (stalled) check({tag, " stall stable"}, 32'({tuser, tlast, tdata}), 32'(held));
      if (tready) begin
        check({tag, " tdata"}, 32'(tdata), 32'(model(pat, x, y, grey)));
        check({tag, " tuser"}, 32'(tuser), 32'(x == 0 && y == 0));
        check({tag, " tlast"}, 32'(tlast), 32'(x == H - 1));
        cap[beats] = tdata;
        if (beats == ev_at) begin
          enable      = ev_en;
          pattern_sel = ev_sel;
        end
        beats++;
        if (x == H - 1) begin
          x = 0;
          y++;
        end else begin
          x++;
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = {tuser, tlast, tdata};
      end
      cycles++;
      cyc();
    end
    exp_fc++;
    check({tag, " beats"}, 32'(beats), 32'(NPIX));
    check({tag, " frame_done"}, 32'(frame_done), 32'd1);
    check({tag, " frame_count"}, 32'(frame_count), 32'(exp_fc));
    if (!bp) check({tag, " cycles"}, 32'(cycles), 32'(NPIX));
  endtask

  initial begin
    // ---- reset state -------------------------------------------------------
    #12;
    check("rst tvalid", 32'(tvalid), 32'd0);
    check("rst tuser", 32'(tuser), 32'd0);
    check("rst tlast", 32'(tlast), 32'd0);
    check("rst tdata", 32'(tdata), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst frame_count", 32'(frame_count), 32'd0);

    // ---- colour bars, enable dropped right after the first beat ------------
    @(negedge clk);
    ap_rst_n    = 1'b1;
    enable      = 1'b1;
    pattern_sel = 2'd0;
    tready      = 1'b1;
    cyc();
    check("bars first tuser", 32'(tuser), 32'd1);
    run_frame("bars1", 0, 8'h00, 1'b0, 0, 1'b0, 2'd0);
    check("bars cap(0,0)", 32'(cap[0]), 32'h00FFFFFF);
    check("bars cap(8,0)", 32'(cap[8]), 32'h00FF00FF);
    check("bars cap(56,0)", 32'(cap[56]), 32'h00000000);
    check("bars1 idle tvalid", 32'(tvalid), 32'd0);
    cyc();
    check("bars1 done pulse end", 32'(frame_done), 32'd0);
    check("bars1 still idle", 32'(tvalid), 32'd0);

    // ---- ramp under random backpressure ------------------------------------
    pattern_sel = 2'd1;
    enable      = 1'b1;
    cyc();
    run_frame("ramp", 1, 8'h00, 1'b1, 0, 1'b0, 2'd1);
    check("ramp cap(63,0)", 32'(cap[63]), 32'h003F3F3F);
    check("ramp idle tvalid", 32'(tvalid), 32'd0);

    // ---- checker with mid-frame sel change, then bars with enable drop -----
    pattern_sel = 2'd2;
    enable      = 1'b1;
    cyc();
    run_frame("chk", 2, 8'h00, 1'b0, 200, 1'b1, 2'd0);
    check("chk cap(8,0)", 32'(cap[8]), 32'h00FFFFFF);
    check("chk cap(8,8)", 32'(cap[8 * H + 8]), 32'h00000000);
    check("chk cap(0,8)", 32'(cap[8 * H]), 32'h00FFFFFF);
    run_frame("bars2", 0, 8'h00, 1'b0, 100, 1'b0, 2'd0);
    check("bars2 cap(8,0)", 32'(cap[8]), 32'h00FF00FF);
    check("bars2 idle tvalid", 32'(tvalid), 32'd0);
    cyc();
    check("bars2 still idle", 32'(tvalid), 32'd0);

    // ---- grey over back-to-back frames -------------------------------------
    pattern_sel = 2'd3;
    enable      = 1'b1;
    cyc();
    run_frame("grey0", 3, exp_fc[7:0], 1'b0, -1, 1'b1, 2'd3);
    check("grey0 cap last", 32'(cap[NPIX - 1]), 32'h00040404);
    run_frame("grey1", 3, exp_fc[7:0], 1'b0, -1, 1'b1, 2'd3);
    check("grey1 cap first", 32'(cap[0]), 32'h00050505);
    run_frame("grey2", 3, exp_fc[7:0], 1'b0, 0, 1'b0, 2'd3);
    check("grey2 idle tvalid", 32'(tvalid), 32'd0);

    // ---- asynchronous reset mid-line ---------------------------------------
    pattern_sel = 2'd0;
    enable      = 1'b1;
    tready      = 1'b1;
    cyc();
    repeat (10) cyc();
    check("pre-rst tvalid", 32'(tvalid), 32'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid rst tvalid", 32'(tvalid), 32'd0);
    check("mid rst tuser", 32'(tuser), 32'd0);
    check("mid rst tlast", 32'(tlast), 32'd0);
    check("mid rst tdata", 32'(tdata), 32'd0);
    check("mid rst frame_done", 32'(frame_done), 32'd0);
    check("mid rst frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    ap_rst_n = 1'b1;
    enable   = 1'b1;
    cyc();
    enable = 1'b0;
    check("post rst tvalid", 32'(tvalid), 32'd1);
    check("post rst tuser", 32'(tuser), 32'd1);
    check("post rst tdata", 32'(tdata), 32'h00FFFFFF);
    check("post rst frame_count", 32'(frame_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

AXI4-Stream video source that drives the 24-bit `video_in_stream` slave port of the Zynq block design: it is the transmitter for the stream the video core receives. It produces full frames of selectable test patterns with SOF on `tuser` and EOL on `tlast`, one pixel per `clk` when the sink is ready. It runs on the same `clk` as the rest of the fabric logic and gives the bench and bring-up a deterministic stimulus source.

## Interface
- `H_ACTIVE`, 64, pixels per line; a multiple of 8, ≥ 8.
- `V_ACTIVE`, 48, lines per frame; ≥ 1.
- `clk`  in  1  sole clock; all logic rising-edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  start/continue frame generation.
- `pattern_sel`  in  2  0 colour bars, 1 horizontal ramp, 2 8×8 checkerboard, 3 frame-count grey.
- `video_in_stream_tdata`  out  24  pixel: [23:16] R, [15:8] B, [7:0] G.
- `video_in_stream_tuser`  out  1  start of frame; high on pixel (0,0) only.
- `video_in_stream_tlast`  out  1  end of line; high on x = H_ACTIVE-1.
- `video_in_stream_tvalid`  out  1  beat valid.
- `video_in_stream_tready`  in  1  sink ready.
- `frame_done`  out  1  one-cycle pulse after the last beat of each frame.
- `frame_count`  out  16  completed frames; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, ACTIVE.
- IDLE: tvalid = 0. If `enable` = 1 at an edge: latch `pattern_sel` into `pat_q`, clear x, y, go ACTIVE.
- ACTIVE: tvalid = 1. Beat transfers on an edge with tvalid & tready. On transfer: x++; at x = H_ACTIVE-1, x→0, y++; at the last pixel (x = H_ACTIVE-1, y = V_ACTIVE-1) the frame ends.
- Frame end: frame_count++, frame_done pulses. If `enable` = 1, relatch `pattern_sel`, stay ACTIVE, and present (0,0) of the next frame at once with no bubble. Otherwise go IDLE.
- `enable` deasserting mid-frame has no effect until the frame end. Frames are never truncated.
- `pattern_sel` is sampled only at frame start. Changes mid-frame are ignored.
- Colour bars: bar = x / (H_ACTIVE/8). Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black, with components 0xFF or 0x00.
- Ramp: R = G = B = x[7:0], wrapping at 256.
- Checkerboard: x[3] ^ y[3] = 1 gives 0xFFFFFF, else 0x000000.
- Grey: R = G = B = frame_count[7:0] as sampled at frame start.
- AXIS rules: once tvalid is high, tdata, tuser and tlast are held stable until the transfer. tvalid never drops without a transfer, except on reset.

## Timing
- Reset (asynchronous, immediate, including mid-frame): state IDLE, x = y = 0. All outputs are 0: tdata, tuser, tlast, tvalid, frame_done, frame_count.
- `enable` sampled high in IDLE at edge N: tvalid = 1 and pixel (0,0) with tuser = 1 are visible after edge N.
- Outputs are registered. The next pixel is presented in the same edge that completes a transfer. Throughput is 1 pixel/cycle when tready is held at 1.
- A frame with tready held at 1 takes exactly H_ACTIVE·V_ACTIVE cycles.
- frame_done is high for the one cycle after the edge that transfers the last beat. frame_count updates on that same edge.
- tready = 0 stalls all counters. Stall length is unbounded.

## Structure
- Package `video_pattern_pkg` holds:
  - the `pattern_e` enum (BARS, RAMP, CHECKER, GREY);
  - the `state_e` enum;
  - the 8 bar colour constants;
  - the RGB field offsets.
- Sub-module `video_pattern_pixel` is combinational and computes the pixel colour from x, y, pattern and grey level. The output register stays in the top.
- Counter widths: $clog2(H_ACTIVE) and $clog2(V_ACTIVE), minimum 1 bit.

## Test plan
- Reset, then `enable` = 1, sel = 0, tready = 1, default parameters:
  - the first beat is 0xFFFFFF with tuser = 1;
  - the beat at x = 8 is 0xFF00FF (yellow, R = FF, B = 00, G = FF);
  - tlast is high on every 64th beat;
  - there are exactly 3072 beats, then frame_done pulses once and frame_count = 1.
- Random tready backpressure with sel = 1: tdata, tuser and tlast stay stable while stalled, and the ramp value equals x on every accepted beat.
- sel = 2 is toggled to 0 mid-frame: that frame stays checkerboard, and pixel (8,0) = 0xFFFFFF, (8,8) = 0x000000. The next frame is colour bars.
- `enable` is dropped at pixel 100: the frame finishes (3072 beats), then tvalid = 0 and the FSM is in IDLE.
- sel = 3 over continuous frames: frame k is solid k[7:0] on all channels, and there are zero idle cycles between frames.
- `ap_rst_n` is asserted mid-line with tvalid high: all outputs are 0 immediately. After release and `enable`, pixel (0,0) is sent with tuser = 1 and frame_count = 0.
